prio_encoder_q: RTL and testbench
=================================

Name: prio_encoder_q

Overview:
- Parametrised, registered successor to the 3-input gate-level encoder: N request lines are encoded to a W-bit index.
- Requests are latched into a sticky pending register and served one per handshake.
- Selectable fixed-priority or round-robin arbitration.
- Feeds downstream logic that consumes one encoded index per valid/ready transfer.

Parameters:
- N, 8, number of request inputs (N >= 2).
- W, 3, index width; must equal ceil(log2(N)).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request lines; sampled every rising edge; bit i high records a request from source i.
- mode_rr  in  1  0 = fixed priority (highest index wins), 1 = round-robin.
- out_ready  in  1  downstream accepts out_idx this cycle.
- out_valid  out  1  out_idx holds a granted index.
- out_idx  out  W  encoded index of the granted source.
- pending  out  N  current sticky request register (status).
- busy  out  1  combinational: |pending OR out_valid.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - pending = 0, out_valid = 0, out_idx = 0, rr_ptr = 0.
  - Held while rst_n is low; first update on the first rising edge after release.
- Load condition: load = !out_valid | out_ready (output register empty or being consumed this cycle).
- Winner selection (combinational from the pending register value before the edge):
  - Fixed mode: highest set index of pending.
  - RR mode: first set bit searching upward from rr_ptr, wrapping N-1 -> 0.
- Each rising edge with load = 1:
  - pending != 0: out_valid <= 1, out_idx <= winner, pending[winner] cleared.
  - RR mode only: rr_ptr <= winner+1, wrapping to 0 when winner = N-1. In fixed mode rr_ptr is unchanged.
  - pending == 0: out_valid <= 0; out_idx holds its last value.
- Each rising edge with load = 0: out_valid, out_idx and rr_ptr hold; out_idx must not change while out_valid=1 and out_ready=0.
- Pending update every edge: pending <= (pending & ~clear_mask) | req. Set wins: if req[i] is high on the same edge pending[i] is cleared by a grant, pending[i] stays 1.
- Repeated req on an already-pending bit is merged; no count is kept.
- Latency:
  - req sampled at edge t -> pending set after t -> out_valid/out_idx after edge t+1 at the earliest.
  - Throughput is one grant per cycle while out_ready=1.
- mode_rr may change at any cycle and applies to the next selection. rr_ptr is retained across mode changes.
- Indices are only produced for bits < N. If N < 2^W, out_idx never takes values >= N.
- out_ready while out_valid=0 has no effect beyond load=1.

Test Plan:
1. Reset: assert rst_n=0 mid-run with pending=0x3C, out_valid=1 -> pending=0, out_valid=0, out_idx=0 immediately (before the next edge); after release with req=0 they stay 0.
2. Fixed mode, N=8: pulse req=8'b0010_0110 for one cycle, out_ready=1 -> out_idx 5, 2, 1 on three consecutive cycles starting 2 edges after the pulse, then out_valid=0 and busy=0.
3. Backpressure: out_ready=0, pulse req bit 3 -> out_valid=1, out_idx=3 held. Pulse req bit 7 -> pending=0x80, out_idx stays 3. Set out_ready=1 -> 3 is consumed, next cycle out_idx=7, then out_valid=0.
4. Round-robin: mode_rr=1, req held 0xFF, out_ready=1 -> out_idx sequence 0,1,2,...,7,0,1 with no gaps.
5. Set-wins: fixed mode, req bit 4 held high continuously, out_ready=1 -> out_idx=4 every cycle after the first grant, and pending[4] stays 1.
6. Mode switch: pending=0x81, mode_rr=0 grants 7. Switch to mode_rr=1 with rr_ptr=0 and pulse req bit 7 again -> next grants are 0 then 7.

Source files
------------

// File: rtl/prio_encoder_q.sv
// Registered N-way request encoder: sticky pending bits, fixed-priority or round-robin grant.
// Latency: req edge t -> pending after t -> out_valid/out_idx after t+1; one grant per cycle.
// Backpressure: out_valid/out_idx/rr_ptr hold while out_ready=0; requests keep accumulating in pending.
module prio_encoder_q #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode_rr,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         busy
);

    logic [W-1:0] rr_ptr;
    logic [W-1:0] win_fix;
    logic [W-1:0] win_rr;
    logic [W-1:0] winner;
    logic [W:0]   cand;
    logic         found;
    logic         load;
    logic         grant;
    logic [N-1:0] clear_mask;

    // Last set bit in ascending scan is the highest index.
    always_comb begin
        win_fix = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) win_fix = W'(i);
        end
    end

    // Upward scan from rr_ptr with wrap; cand stays below N since rr_ptr < N.
    always_comb begin
        win_rr = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr} + (W+1)'(k);
            if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
            if (!found && pending[cand[W-1:0]]) begin
                win_rr = cand[W-1:0];
                found  = 1'b1;
            end
        end
    end

    assign winner     = mode_rr ? win_rr : win_fix;
    assign load       = !out_valid || out_ready;
    assign grant      = load && (|pending);
    assign clear_mask = grant ? (N'(1) << winner) : '0;
    assign busy       = (|pending) || out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            rr_ptr    <= '0;
        end else begin
            // A request arriving on the grant edge re-arms the bit (set wins).
            pending <= (pending & ~clear_mask) | req;
            if (load) begin
                out_valid <= |pending;
                if (grant) begin
                    out_idx <= winner;
                    if (mode_rr) rr_ptr <= (winner == W'(N-1)) ? '0 : winner + W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_q.sv
// Bench for prio_encoder_q: directed scenarios followed by randomized traffic against a reference model.
module tb_prio_encoder_q;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         mode_rr;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         busy;

    int tests = 0;
    int fails = 0;

    // Reference state
    logic [N-1:0] m_pend;
    logic         m_valid;
    int           m_idx;
    int           m_ptr;

    prio_encoder_q #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode_rr(mode_rr), .out_ready(out_ready),
        .out_valid(out_valid), .out_idx(out_idx), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick();
        if (!mode_rr) begin
            for (int i = N - 1; i >= 0; i--) if (m_pend[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_edge();
        int w;
        logic [N-1:0] nxt;
        nxt = m_pend;
        if (!m_valid || out_ready) begin
            w = pick();
            if (w >= 0) begin
                m_valid = 1'b1;
                m_idx   = w;
                nxt[w]  = 1'b0;
                if (mode_rr) m_ptr = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_pend = nxt | req;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".valid"},   32'(out_valid), 32'(m_valid));
        chk({tag, ".idx"},     32'(out_idx),   32'(m_idx));
        chk({tag, ".pending"}, 32'(pending),   32'(m_pend));
        chk({tag, ".busy"},    32'(busy),      32'((|m_pend) || m_valid));
    endtask

    // One clock: model follows the edge, DUT is checked on the following falling edge.
    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        cmp_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mode_rr = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp_model("rst0");
        rst_n = 1'b1;

        // Mid-run asynchronous reset with pending=0x3C and a held grant
        req = 8'h01; cyc("t1a");
        req = 8'h3C; cyc("t1b");
        req = '0;
        chk("t1.pend_pre", 32'(pending), 32'h3C);
        chk("t1.valid_pre", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1.async_pend", 32'(pending), 32'd0);
        chk("t1.async_valid", 32'(out_valid), 32'd0);
        chk("t1.async_idx", 32'(out_idx), 32'd0);
        chk("t1.async_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc("t1c"); cyc("t1d");
        chk("t1.post_pend", 32'(pending), 32'd0);

        // Fixed priority decode of 0x26
        out_ready = 1'b1;
        req = 8'h26; cyc("t2a");
        req = '0;
        cyc("t2b"); chk("t2.first", 32'(out_idx), 32'd5);
        cyc("t2c"); chk("t2.second", 32'(out_idx), 32'd2);
        cyc("t2d"); chk("t2.third", 32'(out_idx), 32'd1);
        cyc("t2e"); chk("t2.drain_valid", 32'(out_valid), 32'd0);
        chk("t2.drain_busy", 32'(busy), 32'd0);

        // Backpressure holds the index while later requests queue
        out_ready = 1'b0;
        req = 8'h08; cyc("t3a");
        req = '0;    cyc("t3b"); chk("t3.idx3", 32'(out_idx), 32'd3);
        req = 8'h80; cyc("t3c"); chk("t3.pend80", 32'(pending), 32'h80);
        chk("t3.hold3", 32'(out_idx), 32'd3);
        req = '0;    cyc("t3d"); chk("t3.hold3b", 32'(out_idx), 32'd3);
        out_ready = 1'b1;
        cyc("t3e"); chk("t3.idx7", 32'(out_idx), 32'd7);
        cyc("t3f"); chk("t3.empty", 32'(out_valid), 32'd0);

        // Round-robin sweep over all sources
        do_reset();
        mode_rr = 1'b1; out_ready = 1'b1; req = 8'hFF;
        cyc("t4a");
        for (int e = 0; e < 10; e++) begin
            cyc("t4");
            chk("t4.rr_seq", 32'(out_idx), 32'(e % N));
            chk("t4.rr_valid", 32'(out_valid), 32'd1);
        end

        // Set wins over a simultaneous grant clear
        do_reset();
        mode_rr = 1'b0; req = 8'h10;
        cyc("t5a");
        for (int e = 0; e < 5; e++) begin
            cyc("t5");
            chk("t5.idx4", 32'(out_idx), 32'd4);
            chk("t5.pend4", 32'(pending[4]), 32'd1);
        end
        req = '0;
        cyc("t5b"); cyc("t5c");
        chk("t5.drain", 32'(out_valid), 32'd0);

        // Mode switch keeps rr_ptr at 0 after fixed grants
        do_reset();
        mode_rr = 1'b0; out_ready = 1'b1; req = 8'h81;
        cyc("t6a");
        req = '0;
        cyc("t6b"); chk("t6.fixed7", 32'(out_idx), 32'd7);
        mode_rr = 1'b1; req = 8'h80;
        cyc("t6c"); chk("t6.rr0", 32'(out_idx), 32'd0);
        req = '0;
        cyc("t6d"); chk("t6.rr7", 32'(out_idx), 32'd7);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            req = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) mode_rr = ~mode_rr;
            out_ready = ($urandom_range(0, 3) != 0);
            cyc("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
